// File: rtl/fetcher_pkg.sv
// ============================================================================
// fetcher_pkg : shared constants, FSM encoding and cache index/tag helpers
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetcher_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  // Instructions are one word; the two byte-offset bits never reach the cache.
  localparam int WORD_LSB    = 2;
  localparam int WORD_ADDR_W = DATA_WIDTH - WORD_LSB;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_DELIVER  = 3'd2,
    ST_WAIT_PC  = 3'd3,
    ST_DRAIN    = 3'd4
  } fetch_state_t;

  // Byte-address ranges: index is [idx_hi:WORD_LSB], tag is [DATA_WIDTH-1:tag_lo].
  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int idx_hi(input int lines);
    return index_bits(lines) + WORD_LSB - 1;
  endfunction

  function automatic int tag_lo(input int lines);
    return index_bits(lines) + WORD_LSB;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetcher_icache.sv
// ============================================================================
// icache : direct-mapped, one-word-per-line instruction cache (word-addressed)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module icache
  import fetcher_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_ADDR_W-1:0] lookup_word,
  output logic                   lookup_hit,
  output logic [DATA_WIDTH-1:0]  lookup_data,
  input  logic                   fill_en,
  input  logic [WORD_ADDR_W-1:0] fill_word,
  input  logic [DATA_WIDTH-1:0]  fill_data
);

  localparam int IDX_W = index_bits(LINES);
  localparam int TAG_W = WORD_ADDR_W - IDX_W;

  logic [LINES-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [DATA_WIDTH-1:0] r_data [LINES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_fill_idx;

  assign w_lk_idx    = lookup_word[IDX_W-1:0];
  assign w_fill_idx  = fill_word[IDX_W-1:0];
  assign lookup_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == lookup_word[WORD_ADDR_W-1:IDX_W]);
  assign lookup_data = r_data[w_lk_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (fill_en) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      r_tag[w_fill_idx]  <= fill_word[WORD_ADDR_W-1:IDX_W];
      r_data[w_fill_idx] <= fill_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetcher.sv
// ============================================================================
// fetcher : instruction fetch FSM with optional direct-mapped icache
//           (cache present only when macro ICACHE_EN is defined)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetcher
  import fetcher_pkg::*;
#(
  parameter int ICACHE_LINES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_next_pc,
  output logic                  out_pc_ena,
  output logic [DATA_WIDTH-1:0] out_last_pc,
  output logic [DATA_WIDTH-1:0] out_last_inst,
  input  logic                  in_clear,
  output logic                  out_mem_req,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  input  logic                  in_mem_valid,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  output logic                  out_inst_valid,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [DATA_WIDTH-1:0] out_inst_pc,
  input  logic                  in_issue_stall
);

  if ((ICACHE_LINES < 4) || (ICACHE_LINES > 256) ||
      ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two in 4..256");
  end

  fetch_state_t          r_state;
  fetch_state_t          w_next;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic                  r_clear_d;
  logic                  r_inst_valid;
  logic [DATA_WIDTH-1:0] r_inst;
  logic [DATA_WIDTH-1:0] r_inst_pc;
  logic [DATA_WIDTH-1:0] r_last_pc;
  logic [DATA_WIDTH-1:0] r_last_inst;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_cache_data;
  logic                  w_mem_req;
  logic                  w_accept;
  logic                  w_unused;

  assign w_unused = ^in_next_pc[WORD_LSB-1:0];

`ifdef ICACHE_EN
  logic w_fill;
  assign w_fill = (r_state == ST_WAIT_MEM) && in_mem_valid && !in_clear;

  icache #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (r_fetch_pc[DATA_WIDTH-1:WORD_LSB]),
    .lookup_hit  (w_hit),
    .lookup_data (w_cache_data),
    .fill_en     (w_fill),
    .fill_word   (r_fetch_pc[DATA_WIDTH-1:WORD_LSB]),
    .fill_data   (in_mem_data)
  );
`else
  assign w_hit        = 1'b0;
  assign w_cache_data = ZERO_DATA;
`endif

  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (w_hit) begin
          w_next = in_clear ? ST_WAIT_PC : ST_DELIVER;
        end else begin
          w_mem_req = 1'b1;
          w_next    = in_clear ? ST_DRAIN : ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: begin
        w_mem_req = 1'b1;
        if (in_mem_valid)  w_next = in_clear ? ST_WAIT_PC : ST_DELIVER;
        else if (in_clear) w_next = ST_DRAIN;
      end
      ST_DELIVER: begin
        if (in_clear) begin
          w_next = ST_WAIT_PC;
        end else if (!in_issue_stall) begin
          w_accept = 1'b1;
          w_next   = ST_WAIT_PC;
        end
      end
      ST_WAIT_PC: w_next = in_clear ? ST_WAIT_PC : ST_FETCH;
      // The outstanding request stays visible until its response is swallowed.
      ST_DRAIN: begin
        w_mem_req = 1'b1;
        if (in_mem_valid) w_next = in_clear ? ST_WAIT_PC : ST_FETCH;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_fetch_pc   <= ZERO_DATA;
      r_clear_d    <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= ZERO_DATA;
      r_inst_pc    <= ZERO_DATA;
      r_last_pc    <= ZERO_DATA;
      r_last_inst  <= ZERO_DATA;
    end else begin
      r_state      <= w_next;
      r_clear_d    <= in_clear;
      r_inst_valid <= (w_next == ST_DELIVER);
      if ((r_state == ST_WAIT_PC) || r_clear_d) begin
        r_fetch_pc <= {in_next_pc[DATA_WIDTH-1:WORD_LSB], {WORD_LSB{1'b0}}};
      end
      if ((r_state == ST_FETCH) && w_hit && !in_clear) begin
        r_inst    <= w_cache_data;
        r_inst_pc <= r_fetch_pc;
      end else if ((r_state == ST_WAIT_MEM) && in_mem_valid && !in_clear) begin
        r_inst    <= in_mem_data;
        r_inst_pc <= r_fetch_pc;
      end
      if (w_accept) begin
        r_last_pc   <= r_inst_pc;
        r_last_inst <= r_inst;
      end
    end
  end

  assign out_mem_req    = w_mem_req && !rst;
  assign out_mem_addr   = out_mem_req ? r_fetch_pc : ZERO_DATA;
  assign out_pc_ena     = !rst && (in_clear || w_accept);
  assign out_inst_valid = r_inst_valid;
  assign out_inst       = r_inst;
  assign out_inst_pc    = r_inst_pc;
  assign out_last_pc    = r_last_pc;
  assign out_last_inst  = r_last_inst;

endmodule

`default_nettype wire

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter ICACHE_LINES, default 64, number of direct-mapped one-word cache lines (power of two, 4..256).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_next_pc  input  32  next fetch address from the PC stage, valid the cycle after out_pc_ena was high.
REQ-005 out_pc_ena  output  1  enable to the PC stage; high one cycle to request a new next-PC.
REQ-006 out_last_pc / out_last_inst  output  32/32  PC and word of the last delivered instruction, fed back to the PC stage.
REQ-007 in_clear  input  1  misbranch flush from branch forwarding.
REQ-008 out_mem_req / out_mem_addr  output  1/32  word read request to the memory controller.
REQ-009 in_mem_valid / in_mem_data  input  1/32  read response, one pulse per request.
REQ-010 out_inst_valid / out_inst / out_inst_pc  output  1/32/32  instruction to the decoder.
REQ-011 in_issue_stall  input  1  decoder/queue full; instruction is not accepted while high.

Function
REQ-012 FSM states: FETCH, WAIT_MEM, DELIVER, WAIT_PC, DRAIN; register fetch_pc holds the current fetch address.
REQ-013 FETCH: on hit, load out_inst/out_inst_pc from the cache and go to DELIVER next cycle; on miss, drive out_mem_req=1 and out_mem_addr=fetch_pc and go to WAIT_MEM.
REQ-014 WAIT_MEM: hold out_mem_req and out_mem_addr stable; on in_mem_valid, capture the data, fill the line (index fetch_pc[idx+1:2], tag fetch_pc[31:idx+2]), drop out_mem_req, go to DELIVER.
REQ-015 DELIVER: out_inst_valid=1; the instruction is accepted in a cycle with in_issue_stall=0; on acceptance, pulse out_pc_ena, update out_last_pc/out_last_inst, go to WAIT_PC; otherwise hold all outputs stable.
REQ-016 WAIT_PC: lasts exactly one cycle; latch in_next_pc into fetch_pc, go to FETCH.
REQ-017 Hit latency: FETCH to out_inst_valid is 1 cycle; steady hit throughput is 1 instruction per 3 cycles.
REQ-018 in_clear in any state: out_inst_valid=0 the next cycle and out_pc_ena=1 the same cycle (combinational); the next cycle latches in_next_pc into fetch_pc.
REQ-019 in_clear while in WAIT_MEM, or in FETCH with a miss: go to DRAIN, wait for in_mem_valid, discard the data without filling, then go to FETCH.
REQ-020 in_clear in any other state: go to WAIT_PC.
REQ-021 in_clear and in_mem_valid in the same cycle: discard the data, no fill, go to WAIT_PC.
REQ-022 in_clear has priority over DELIVER acceptance: an instruction offered in the clear cycle is not accepted.
REQ-023 Address arithmetic is 32-bit modulo; addresses are word-aligned and fetch_pc[1:0] is ignored.

Reset
REQ-024 rst: state=FETCH, fetch_pc=0, all cache valid bits=0.
REQ-025 rst: out_mem_req=0, out_mem_addr=0, out_inst_valid=0, out_inst=0, out_inst_pc=0, out_pc_ena=0, out_last_pc=0, out_last_inst=0.
REQ-026 rst during WAIT_MEM or DRAIN abandons the request; a response arriving after reset is ignored in any state other than WAIT_MEM/DRAIN.

Configuration
REQ-027 Macro ICACHE_EN defined: the cache is present as described.
REQ-028 ICACHE_EN undefined: no cache storage; FETCH always treats the access as a miss and every instruction comes from memory; all other behaviour is unchanged.

Structure
REQ-029 The shared constant header holds DATA_WIDTH, ZERO_DATA, the FSM state encodings and the cache index/tag range macros.
REQ-030 The cache is a sub-module icache (lookup/fill ports, valid-bit clear on rst); fetcher instantiates it only under ICACHE_EN.

Verification
REQ-031 Reset, then memory returns 0x00000013 for addr 0 after 3 cycles -> out_inst_valid=1 with out_inst=0x00000013, out_inst_pc=0; out_pc_ena pulses once.
REQ-032 Refetch addr 0 after a cold miss (ICACHE_EN) -> no out_mem_req; out_inst_valid 1 cycle after FETCH.
REQ-033 in_issue_stall=1 for 5 cycles in DELIVER -> outputs held constant, no out_pc_ena until the stall drops.
REQ-034 in_clear during WAIT_MEM for addr 0x40, then in_next_pc=0x100 -> 0x40 data discarded, not cached, next request addr=0x100.
REQ-035 Addresses 0x000 and 0x100 with ICACHE_LINES=64 (alias) -> second access misses and evicts the first; refetch of 0x000 misses.
REQ-036 ICACHE_EN undefined, same address fetched twice -> two memory requests.
